// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//
// Word-addressed data memory for the MEM stage. It services one load or store
// at a time through a request/ready handshake and inserts WAIT_CYCLES wait
// states between request capture and the array access to model slow memory.
// Misaligned addresses and addresses outside the window are rejected with
// addrError, so no write can land outside [BASE_ADDR, BASE_ADDR + DEPTH*4).
//
// Parameters:
//   BASE_ADDR   - byte address of word 0
//   DEPTH       - number of 32-bit words (power of two, 4..1024)
//   WAIT_CYCLES - extra cycles between capture and access (0..15)
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous, active-high reset
//   memRead   - load request
//   memWrite  - store request (wins over memRead when both are high)
//   address   - byte address, normally ALUresult
//   writeData - store data
//   DMresult  - load data, held between loads
//   DMready   - one-cycle pulse when a transaction completes
//   addrError - qualifies DMready; the transaction was rejected
// -----------------------------------------------------------------------------
module data_memory #(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] DMresult,
    output logic        DMready,
    output logic        addrError
);

    localparam int unsigned IdxW      = $clog2(DEPTH);
    localparam logic [31:0] SpanBytes = 32'(DEPTH) << 2;
    // Counter load value when entering WAIT; counts down to 0 inclusive.
    localparam logic [3:0]  WaitInit  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e            state_q;
    logic [IdxW-1:0]   idx_q;
    logic [31:0]       wdata_q;
    logic              is_write_q;
    logic [3:0]        cnt_q;
    logic [31:0]       mem_q [DEPTH];

    // Address decode of the incoming request. The offset subtraction is allowed
    // to wrap, so addresses below BASE_ADDR become huge offsets and fail the
    // range test.
    logic [31:0]       offset_in;
    logic              valid_in;
    logic [IdxW-1:0]   idx_in;

    always_comb begin
        offset_in = address - BASE_ADDR;
        valid_in  = (address[1:0] == 2'b00) && (offset_in < SpanBytes);
        idx_in    = offset_in[IdxW+1:2];
    end

    // Single-process FSM; DMresult, DMready and addrError are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            cnt_q      <= '0;
            DMresult   <= '0;
            DMready    <= 1'b0;
            addrError  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            DMready   <= 1'b0;
            addrError <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (memRead || memWrite) begin
                        // Only the decoded word index is kept; it is all the
                        // access needs once validity is known.
                        idx_q      <= idx_in;
                        wdata_q    <= writeData;
                        is_write_q <= memWrite;

                        if (!valid_in) begin
                            state_q   <= StDone;
                            DMready   <= 1'b1;
                            addrError <= 1'b1;
                        end else if (WAIT_CYCLES == 0) begin
                            if (memWrite) begin
                                mem_q[idx_in] <= writeData;
                            end else begin
                                DMresult <= mem_q[idx_in];
                            end
                            state_q <= StDone;
                            DMready <= 1'b1;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= WaitInit;
                        end
                    end
                end

                StWait: begin
                    // Inputs are ignored here; only latched values are used.
                    if (cnt_q == 4'd0) begin
                        if (is_write_q) begin
                            mem_q[idx_q] <= wdata_q;
                        end else begin
                            DMresult <= mem_q[idx_q];
                        end
                        state_q <= StDone;
                        DMready <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
//
// Directed bench for data_memory. Four instances with WAIT_CYCLES = 3, 1, 0, 2
// share clock and reset; each test drives one instance.
// -----------------------------------------------------------------------------
module tb_data_memory;

    localparam int NDut = 4;

    logic        clk;
    logic        reset;
    logic        mem_read  [NDut];
    logic        mem_write [NDut];
    logic [31:0] addr      [NDut];
    logic [31:0] wdata     [NDut];
    logic [31:0] dm_result [NDut];
    logic        dm_ready  [NDut];
    logic        addr_err  [NDut];

    int n_checks;
    int n_fail;

    for (genvar g = 0; g < NDut; g++) begin : g_dut
        data_memory #(
            .BASE_ADDR  (32'h1001_0000),
            .DEPTH      (64),
            .WAIT_CYCLES((g == 0) ? 3 : (g == 1) ? 1 : (g == 2) ? 0 : 2)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .memRead  (mem_read[g]),
            .memWrite (mem_write[g]),
            .address  (addr[g]),
            .writeData(wdata[g]),
            .DMresult (dm_result[g]),
            .DMready  (dm_ready[g]),
            .addrError(addr_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Drives one request, waits (bounded) for DMready,
    // drops the request in the DMready cycle, then checks the pulse is a
    // single cycle. Returns at the negedge of the following IDLE cycle.
    task automatic xact(input int d, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] res,
                        output logic err);
        logic got;
        mem_read[d]  = rd;
        mem_write[d] = wr;
        addr[d]      = a;
        wdata[d]     = wd;
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dm_ready[d]) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        check("ready_seen", {31'd0, got}, 32'd1);
        mem_read[d]  = 1'b0;
        mem_write[d] = 1'b0;
        res = dm_result[d];
        err = addr_err[d];
        @(negedge clk);
        check("ready_pulse_width", {31'd0, dm_ready[d]}, 32'd0);
    endtask

    logic [31:0] fib [11];
    logic [31:0] res;
    logic        err;
    int          lat;
    logic        seen;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        fib = '{32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34, 32'd55, 32'd89,
                32'd144};
        for (int d = 0; d < NDut; d++) begin
            mem_read[d]  = 1'b0;
            mem_write[d] = 1'b0;
            addr[d]      = '0;
            wdata[d]     = '0;
        end

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDut; d++) begin
            check("rst_result", dm_result[d], 32'd0);
            check("rst_ready", {31'd0, dm_ready[d]}, 32'd0);
            check("rst_err", {31'd0, addr_err[d]}, 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // 1. Reset mid-WAIT, WAIT_CYCLES=3
        mem_write[0] = 1'b1;
        addr[0]      = 32'h1001_0010;
        wdata[0]     = 32'h5;
        @(posedge clk);
        @(negedge clk);
        check("t1_no_ready_in_wait", {31'd0, dm_ready[0]}, 32'd0);
        reset = 1'b1;
        #1;
        check("t1_rst_result", dm_result[0], 32'd0);
        check("t1_rst_ready", {31'd0, dm_ready[0]}, 32'd0);
        check("t1_rst_err", {31'd0, addr_err[0]}, 32'd0);
        mem_write[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dm_ready[0]) seen = 1'b1;
        end
        check("t1_aborted_no_ready", {31'd0, seen}, 32'd0);
        xact(0, 1'b1, 1'b0, 32'h1001_0010, 32'h0, lat, res, err);
        check("t1_load_value", res, 32'd0);
        check("t1_load_lat", lat, 32'd3);
        check("t1_load_err", {31'd0, err}, 32'd0);

        // 2. Fibonacci fill, WAIT_CYCLES=1
        for (int i = 0; i < 11; i++) begin
            xact(1, 1'b0, 1'b1, 32'h1001_0004 + 32'(4 * i), fib[i], lat, res, err);
            check("t2_store_lat", lat, 32'd1);
            check("t2_store_err", {31'd0, err}, 32'd0);
            check("t2_store_keeps_result", res, 32'd0);
        end
        for (int i = 0; i < 11; i++) begin
            xact(1, 1'b1, 1'b0, 32'h1001_0004 + 32'(4 * i), 32'h0, lat, res, err);
            check("t2_load_value", res, fib[i]);
            check("t2_load_lat", lat, 32'd1);
            check("t2_load_err", {31'd0, err}, 32'd0);
        end

        // 3. Bad addresses on the same instance
        xact(1, 1'b1, 1'b0, 32'h1001_0006, 32'h0, lat, res, err);
        check("t3_misaligned_err", {31'd0, err}, 32'd1);
        check("t3_misaligned_result", res, 32'h90);
        xact(1, 1'b1, 1'b0, 32'h1001_0100, 32'h0, lat, res, err);
        check("t3_range_err", {31'd0, err}, 32'd1);
        check("t3_range_result", res, 32'h90);
        xact(1, 1'b1, 1'b0, 32'h1000_FFFC, 32'h0, lat, res, err);
        check("t3_below_err", {31'd0, err}, 32'd1);
        check("t3_below_result", res, 32'h90);
        xact(1, 1'b0, 1'b1, 32'h1001_0006, 32'hBAD, lat, res, err);
        check("t3_bad_store_err", {31'd0, err}, 32'd1);
        check("t3_bad_store_result", res, 32'h90);
        xact(1, 1'b0, 1'b1, 32'h1001_0100, 32'hBAD, lat, res, err);
        check("t3_oor_store_err", {31'd0, err}, 32'd1);
        xact(1, 1'b1, 1'b0, 32'h1001_0004, 32'h0, lat, res, err);
        check("t3_word1_intact", res, 32'd1);
        xact(1, 1'b1, 1'b0, 32'h1001_0000, 32'h0, lat, res, err);
        check("t3_word0_intact", res, 32'd0);
        xact(1, 1'b1, 1'b0, 32'h1001_0008, 32'h0, lat, res, err);
        check("t3_word2_intact", res, 32'd2);

        // 4. memRead and memWrite both high: write wins
        xact(1, 1'b1, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF, lat, res, err);
        check("t4_err", {31'd0, err}, 32'd0);
        check("t4_result_unchanged", res, 32'd2);
        xact(1, 1'b1, 1'b0, 32'h1001_0000, 32'h0, lat, res, err);
        check("t4_load_value", res, 32'hDEAD_BEEF);

        // 5. WAIT_CYCLES=0, back-to-back on the last word
        xact(2, 1'b0, 1'b1, 32'h1001_00FC, 32'hA5, lat, res, err);
        check("t5_store_lat", lat, 32'd0);
        check("t5_store_err", {31'd0, err}, 32'd0);
        check("t5_store_result", res, 32'd0);
        xact(2, 1'b1, 1'b0, 32'h1001_00FC, 32'h0, lat, res, err);
        check("t5_load_lat", lat, 32'd0);
        check("t5_load_value", res, 32'hA5);
        xact(2, 1'b1, 1'b0, 32'h1001_0100, 32'h0, lat, res, err);
        check("t5_range_err", {31'd0, err}, 32'd1);
        check("t5_range_result", res, 32'hA5);

        // 6. Inputs changed during WAIT, WAIT_CYCLES=2
        mem_write[3] = 1'b1;
        addr[3]      = 32'h1001_0008;
        wdata[3]     = 32'h1234;
        @(posedge clk);
        @(negedge clk);
        addr[3]  = 32'h1001_000C;
        wdata[3] = 32'hFFFF;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (dm_ready[3]) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("t6_ready_seen", {31'd0, seen}, 32'd1);
        check("t6_lat", lat, 32'd2);
        check("t6_err", {31'd0, addr_err[3]}, 32'd0);
        mem_write[3] = 1'b0;
        @(negedge clk);
        xact(3, 1'b1, 1'b0, 32'h1001_0008, 32'h0, lat, res, err);
        check("t6_latched_addr_value", res, 32'h1234);
        xact(3, 1'b1, 1'b0, 32'h1001_000C, 32'h0, lat, res, err);
        check("t6_changed_addr_untouched", res, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
